cwt_scalogram_sink: RTL and testbench

//  Downstream consumer of the cwt core result stream. Captures one scalogram frame of
//  N*J1 complex coefficients, converts each one to power |X|^2, and buffers the frame.
//  It then streams the frame to the deep-learning front end over valid/ready.
//  It drives the cwt core's dl_busy_i, so no new frame can arrive while a drain is in progress.

---
 rtl/cwt_scalogram_sink.sv | 151 +++++++++++++++
 tb/tb_cwt_scalogram_sink.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cwt_scalogram_sink.sv
// cwt_scalogram_sink: captures one scalogram frame of complex CWT coefficients,
// converts each to power |X|^2 (shifted, saturated), buffers it, then drains the
// frame over a valid/ready stream while holding the cwt core off with dl_busy_o.
module cwt_scalogram_sink #(
  parameter int N      = 1024,
  parameter int J1     = 4,
  parameter int DATA_W = 32,
  parameter int OUT_W  = 32,
  parameter int SHIFT  = 16,
  localparam int SW    = (J1 > 1) ? $clog2(J1) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cwt_done_i,
  input  logic [DATA_W-1:0] X_re_i,
  input  logic [DATA_W-1:0] X_im_i,
  output logic              dl_busy_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [OUT_W-1:0]  m_data_o,
  output logic [SW-1:0]     m_scale_o,
  output logic              m_last_o,
  output logic              overflow_o
);

  localparam int TOTAL = N * J1;
  localparam int AW    = $clog2(TOTAL);
  localparam int NB    = $clog2(N);
  localparam int PW    = 2 * DATA_W;
  // Largest power value representable on the output; anything above saturates.
  localparam logic [PW-1:0] OUT_MAX = PW'({OUT_W{1'b1}});

  typedef enum logic [1:0] {IDLE, CAPTURE, FLUSH, DRAIN} state_t;

  state_t                   state, state_nxt;
  logic                     accept, drop;
  logic [AW-1:0]            in_cnt, wr_cnt, ld_cnt;
  logic [AW:0]              rd_cnt;
  logic                     s1_valid;
  logic signed [DATA_W-1:0] re_s, im_s;
  logic signed [PW-1:0]     p_re, p_im;
  logic [PW-1:0]            pwr_sum, pwr_shift;
  logic [OUT_W-1:0]         pwr_sat;
  logic [OUT_W-1:0]         mem [TOTAL];
  logic [OUT_W-1:0]         rd_data;
  logic                     rd_pend, rd_en, load, out_accept, last_accept;

  assign re_s = X_re_i;
  assign im_s = X_im_i;

  // Handshake qualifiers: samples are only taken while idle or capturing, and the
  // output read pipeline advances when the read slot is free or being drained.
  always_comb begin
    accept      = cwt_done_i && ((state == IDLE) || (state == CAPTURE));
    drop        = cwt_done_i && ((state == FLUSH) || (state == DRAIN));
    out_accept  = m_valid_o && m_ready_i;
    last_accept = out_accept && m_last_o;
    load        = (state == DRAIN) && rd_pend && (!m_valid_o || out_accept);
    rd_en       = (state == DRAIN) && (rd_cnt < (AW+1)'(TOTAL)) && (!rd_pend || load);
  end

  // Next-state logic; FLUSH lasts until the last product has left stage 1.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = CAPTURE;
      CAPTURE: if (accept && (in_cnt == AW'(TOTAL - 1))) state_nxt = FLUSH;
      FLUSH:   if (!s1_valid) state_nxt = DRAIN;
      DRAIN:   if (last_accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State register, accepted-sample count, registered busy and sticky overflow.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      in_cnt     <= '0;
      dl_busy_o  <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      dl_busy_o <= (state_nxt == FLUSH) || (state_nxt == DRAIN);
      if (accept) in_cnt <= in_cnt + 1'b1;
      if (drop) overflow_o <= 1'b1;
    end
  end

  // Stage 2 combinational part: sum of squares, scale down, clamp to output width.
  always_comb begin
    pwr_sum   = $unsigned(p_re) + $unsigned(p_im);
    pwr_shift = pwr_sum >> SHIFT;
    pwr_sat   = (pwr_shift > OUT_MAX) ? '1 : pwr_shift[OUT_W-1:0];
  end

  // Stage 1 squares the components; stage 2 write address advances per result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_valid <= 1'b0;
      p_re     <= '0;
      p_im     <= '0;
      wr_cnt   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        p_re <= PW'(re_s) * PW'(re_s);
        p_im <= PW'(im_s) * PW'(im_s);
      end
      if (s1_valid) wr_cnt <= wr_cnt + 1'b1;
    end
  end

  // Frame buffer: write from stage 2, registered read for the drain path.
  always_ff @(posedge clk) begin
    if (s1_valid) mem[wr_cnt] <= pwr_sat;
    if (rd_en) rd_data <= mem[rd_cnt[AW-1:0]];
  end

  // Drain path: read prefetch, output register with scale/last tags, and
  // counter clear once the final word has been handed off.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_cnt    <= '0;
      ld_cnt    <= '0;
      rd_pend   <= 1'b0;
      m_valid_o <= 1'b0;
      m_data_o  <= '0;
      m_scale_o <= '0;
      m_last_o  <= 1'b0;
    end else begin
      if (last_accept) begin
        rd_cnt <= '0;
        ld_cnt <= '0;
      end else begin
        if (rd_en) rd_cnt <= rd_cnt + 1'b1;
        if (load) ld_cnt <= ld_cnt + 1'b1;
      end
      rd_pend <= rd_en || (rd_pend && !load);
      if (load) begin
        m_valid_o <= 1'b1;
        m_data_o  <= rd_data;
        m_scale_o <= SW'(ld_cnt >> NB);
        m_last_o  <= (ld_cnt == AW'(TOTAL - 1));
      end else if (out_accept) begin
        m_valid_o <= 1'b0;
        m_last_o  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cwt_scalogram_sink.sv
// Bench for cwt_scalogram_sink: two instances (SHIFT=0 and SHIFT=16) share one
// input stream; a frame-level power model feeds per-instance expected queues.
module tb_cwt_scalogram_sink;

  localparam int N     = 16;
  localparam int J1    = 2;
  localparam int TOTAL = N * J1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cwt_done = 1'b0;
  logic        m_ready = 1'b1;
  logic [31:0] x_re = '0;
  logic [31:0] x_im = '0;

  logic        dl_busy  [2];
  logic        m_valid  [2];
  logic        m_last   [2];
  logic        overflow [2];
  logic [31:0] m_data   [2];
  logic [0:0]  m_scale  [2];

  int          passed = 0;
  int          total = 0;
  logic [31:0] exp_q [2][$];
  int          widx [2];
  bit          end_pend [2];
  bit          stall_prev [2];
  int          run_len = 0;
  int          last_run = 0;
  int          lat_cnt = 0;
  int          first_lat = 0;
  bit          lat_on = 1'b0;
  bit          busy_prev = 1'b0;
  bit          ready_rand = 1'b0;
  logic [31:0] fr_re [TOTAL];
  logic [31:0] fr_im [TOTAL];

  always #5 clk = ~clk;

  cwt_scalogram_sink #(.N(N), .J1(J1), .DATA_W(32), .OUT_W(32), .SHIFT(0)) u_dut0 (
    .clk(clk), .rstn(rstn), .cwt_done_i(cwt_done), .X_re_i(x_re), .X_im_i(x_im),
    .dl_busy_o(dl_busy[0]), .m_valid_o(m_valid[0]), .m_ready_i(m_ready),
    .m_data_o(m_data[0]), .m_scale_o(m_scale[0]), .m_last_o(m_last[0]),
    .overflow_o(overflow[0])
  );

  cwt_scalogram_sink #(.N(N), .J1(J1), .DATA_W(32), .OUT_W(32), .SHIFT(16)) u_dut1 (
    .clk(clk), .rstn(rstn), .cwt_done_i(cwt_done), .X_re_i(x_re), .X_im_i(x_im),
    .dl_busy_o(dl_busy[1]), .m_valid_o(m_valid[1]), .m_ready_i(m_ready),
    .m_data_o(m_data[1]), .m_scale_o(m_scale[1]), .m_last_o(m_last[1]),
    .overflow_o(overflow[1])
  );

  // Reference power: exact |X|^2 in 64 bits, shifted, clamped to 32 bits.
  function automatic logic [31:0] power(input logic [31:0] re, input logic [31:0] im,
                                        input int sh);
    longint r, i;
    logic [63:0] s;
    r = longint'($signed(re));
    i = longint'($signed(im));
    s = $unsigned(r * r) + $unsigned(i * i);
    s = s >> sh;
    return (s > 64'h0000_0000_FFFF_FFFF) ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] req);
    total++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] re, input logic [31:0] im);
    @(posedge clk);
    #1;
    cwt_done = v;
    x_re = re;
    x_im = im;
  endtask

  task automatic pushExpected(input logic [31:0] re, input logic [31:0] im);
    exp_q[0].push_back(power(re, im, 0));
    exp_q[1].push_back(power(re, im, 16));
  endtask

  // gap_mode: 0 back-to-back, 1 alternating valid/idle, 2 random idle cycles.
  task automatic sendFrame(input int gap_mode);
    for (int k = 0; k < TOTAL; k++) begin
      if ((gap_mode == 1 && k > 0) || (gap_mode == 2 && $urandom_range(0, 2) == 0))
        applyStimulus(1'b0, '0, '0);
      applyStimulus(1'b1, fr_re[k], fr_im[k]);
      pushExpected(fr_re[k], fr_im[k]);
      if (k == TOTAL - 1) begin
        @(negedge clk);
        checkOutput("busy_before_last", dl_busy[0], 0);
      end
    end
    applyStimulus(1'b0, '0, '0);
    @(negedge clk);
    checkOutput("busy_after_last", {dl_busy[0], dl_busy[1]}, 2'b11);
  endtask

  task automatic waitDrain();
    int cyc = 0;
    while ((exp_q[0].size() != 0 || exp_q[1].size() != 0 || dl_busy[0]) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("drain_complete", (cyc < 4000), 1);
    @(negedge clk);
  endtask

  task automatic fillRandom();
    for (int k = 0; k < TOTAL; k++) begin
      fr_re[k] = $urandom;
      fr_im[k] = $urandom;
    end
  endtask

  // Output comparison every cycle: the front of each expected queue must be
  // presented (and held under stall); scale/last follow the word index.
  always @(negedge clk) begin
    if (!rstn) begin
      for (int d = 0; d < 2; d++) begin
        exp_q[d].delete();
        widx[d] = 0;
        end_pend[d] = 1'b0;
        stall_prev[d] = 1'b0;
      end
      run_len = 0;
      lat_on = 1'b0;
      busy_prev = 1'b0;
    end else begin
      run_len = m_valid[0] ? run_len + 1 : 0;
      if (dl_busy[0] && !busy_prev) begin
        lat_on = 1'b1;
        lat_cnt = 1;
      end else if (lat_on) begin
        if (m_valid[0]) begin
          first_lat = lat_cnt;
          lat_on = 1'b0;
        end else lat_cnt++;
      end
      busy_prev = dl_busy[0];
      for (int d = 0; d < 2; d++) begin
        if (end_pend[d]) begin
          checkOutput("end_valid_busy", {m_valid[d], dl_busy[d]}, 2'b00);
          end_pend[d] = 1'b0;
        end
        if (stall_prev[d]) checkOutput("stall_hold_valid", m_valid[d], 1);
        if (m_valid[d]) begin
          if (exp_q[d].size() == 0) checkOutput("spurious_word", m_valid[d], 0);
          else begin
            checkOutput("word_data", m_data[d], exp_q[d][0]);
            checkOutput("word_scale_last", {m_scale[d], m_last[d]},
                        {1'(widx[d] / N), (widx[d] == TOTAL - 1)});
            if (m_ready) begin
              void'(exp_q[d].pop_front());
              if (widx[d] == TOTAL - 1) begin
                if (d == 0) last_run = run_len;
                widx[d] = 0;
                end_pend[d] = 1'b1;
              end else widx[d]++;
            end
          end
        end
        stall_prev[d] = m_valid[d] && !m_ready;
      end
    end
  end

  // Downstream ready: constant 1 or 50% random.
  initial forever begin
    @(posedge clk);
    #1;
    m_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] re, im;
    int cyc;

    checkOutput("model_3_m4", power(32'd3, 32'hFFFF_FFFC, 0), 32'd25);
    checkOutput("model_max_sat", power(32'h7FFF_FFFF, 32'h7FFF_FFFF, 16), 32'hFFFF_FFFF);
    checkOutput("model_min_sat", power(32'h8000_0000, 32'd0, 16), 32'hFFFF_FFFF);
    checkOutput("model_256", power(32'd256, 32'd256, 16), 32'd2);
    checkOutput("model_ramp31", power(32'd31, 32'd0, 0), 32'd961);

    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++)
      checkOutput("reset_state", {dl_busy[d], m_valid[d], m_last[d], overflow[d],
                                  m_data[d], m_scale[d]}, '0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] test 1: constant 3-4j");
    for (int k = 0; k < TOTAL; k++) begin
      fr_re[k] = 32'd3;
      fr_im[k] = 32'hFFFF_FFFC;
    end
    sendFrame(0);
    waitDrain();

    $display("[TB] test 2: saturation patterns");
    for (int k = 0; k < TOTAL; k++) begin
      case (k % 3)
        0: begin fr_re[k] = 32'h7FFF_FFFF; fr_im[k] = 32'h7FFF_FFFF; end
        1: begin fr_re[k] = 32'h8000_0000; fr_im[k] = 32'd0; end
        default: begin fr_re[k] = 32'd256; fr_im[k] = 32'd256; end
      endcase
    end
    sendFrame(0);
    waitDrain();

    $display("[TB] test 3: gapped ramp");
    for (int k = 0; k < TOTAL; k++) begin
      fr_re[k] = 32'(k);
      fr_im[k] = 32'd0;
    end
    sendFrame(1);
    waitDrain();

    $display("[TB] test 4: random data, random backpressure");
    ready_rand = 1'b1;
    fillRandom();
    sendFrame(2);
    waitDrain();
    ready_rand = 1'b0;
    fillRandom();
    sendFrame(0);
    waitDrain();
    checkOutput("burst_len", last_run, TOTAL);
    checkOutput("first_valid_latency", first_lat, 4);

    $display("[TB] test 5: overflow");
    for (int i = 0; i < 40; i++) begin
      re = $urandom;
      im = $urandom;
      applyStimulus(1'b1, re, im);
      if (i < TOTAL) pushExpected(re, im);
      @(negedge clk);
      checkOutput("overflow_flag", {overflow[0], overflow[1]}, (i >= 33) ? 2'b11 : 2'b00);
    end
    applyStimulus(1'b0, '0, '0);
    waitDrain();
    checkOutput("overflow_sticky", {overflow[0], overflow[1]}, 2'b11);

    $display("[TB] test 6: reset mid-drain");
    fillRandom();
    sendFrame(0);
    cyc = 0;
    while (widx[0] < 11 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("reach_word10", (cyc < 2000), 1);
    @(posedge clk);
    #1 rstn = 1'b0;
    #1;
    for (int d = 0; d < 2; d++)
      checkOutput("midreset_outputs", {dl_busy[d], m_valid[d], m_last[d], overflow[d],
                                       m_data[d], m_scale[d]}, '0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    fillRandom();
    sendFrame(2);
    waitDrain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
